uart_apb_master: RTL and testbench

- Command bridge that turns a byte stream from a UART receiver into APB master transactions, and returns status and read data as a byte stream to a UART transmitter.
- It is the initiator end of the APB interface that our UART controller and other peripherals respond on.
- Used as a host/debug access path into the APB register space.

---
 rtl/uart_apb_master.sv | 219 +++++++++++++++++++++
 tb/tb_uart_apb_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_master.sv
// uart_apb_master: turns UART command frames into APB master transfers and
// returns a status byte (plus read data) as a UART byte stream.
//   Frames (LSB first): write = 57 addr d0 d1 d2 d3, read = 52 addr.
//   Responses: 4B ok (+4 data bytes on read), 45 slave error, 54 timeout,
//   3F unknown opcode.
// Ports:
//   clk_i, reset_i              clock, async active-high reset
//   rx_data_i/rx_valid_i        received byte strobe (no backpressure)
//   tx_data_o/tx_valid_o/tx_ready_i  response byte handshake
//   psel_o..pslverr_i           APB master interface (8-bit addr, 32-bit data)
//   busy_o                      high whenever the FSM is not idle
//   overrun_o                   same-cycle pulse when an rx byte is dropped
//   timeout_o                   one-cycle pulse when an APB access times out
module uart_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES       = 256,
  parameter int unsigned FRAME_TIMEOUT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [7:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned FT_W = (FRAME_TIMEOUT_CYCLES > 1) ? $clog2(FRAME_TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = TIMEOUT_CYCLES - 1;
  localparam int unsigned FT_LAST = (FRAME_TIMEOUT_CYCLES == 0) ? 0 : FRAME_TIMEOUT_CYCLES - 1;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_TO  = 8'h54;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, APB_SETUP, APB_ACCESS, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        pwrite_q, pwrite_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic [FT_W-1:0] idle_q, idle_d;
  logic [39:0] resp_q, resp_d;     // response bytes, low byte is on tx_data_o
  logic [2:0]  left_q, left_d;     // response bytes still to transfer
  logic        tx_valid_q, tx_valid_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic        frame_expired;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      idle_q     <= '0;
      resp_q     <= '0;
      left_q     <= '0;
      tx_valid_q <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      idle_q     <= idle_d;
      resp_q     <= resp_d;
      left_q     <= left_d;
      tx_valid_q <= tx_valid_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    resp_d     = resp_q;
    left_d     = left_q;
    tx_valid_d = tx_valid_q;
    timeout_d  = 1'b0;

    // Inter-byte idle counter only runs while a frame is partially received
    if (FRAME_TIMEOUT_CYCLES == 0 || rx_valid_i ||
        !(state_q == GET_ADDR || state_q == GET_DATA))
      idle_d = '0;
    else
      idle_d = idle_q + FT_W'(1);
    frame_expired = (FRAME_TIMEOUT_CYCLES != 0) && !rx_valid_i &&
                    (idle_q == FT_W'(FT_LAST));

    case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
            pwrite_d = (rx_data_i == OP_WR);
            state_d  = GET_ADDR;
          end else begin
            resp_d     = {32'h0, RSP_UNK};
            left_d     = 3'd1;
            tx_valid_d = 1'b1;
            state_d    = RESP;
          end
        end
      end
      GET_ADDR: begin
        if (frame_expired) begin
          state_d = IDLE;
        end else if (rx_valid_i) begin
          paddr_d = rx_data_i;
          cnt_d   = 2'd0;
          state_d = pwrite_q ? GET_DATA : APB_SETUP;
        end
      end
      GET_DATA: begin
        if (frame_expired) begin
          state_d = IDLE;
        end else if (rx_valid_i) begin
          pwdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = APB_SETUP;
        end
      end
      APB_SETUP: begin
        wait_d  = '0;
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (pready_i) begin
          tx_valid_d = 1'b1;
          state_d    = RESP;
          left_d     = 3'd1;
          if (pslverr_i) begin
            resp_d = {32'h0, RSP_ERR};
          end else if (pwrite_q) begin
            resp_d = {32'h0, RSP_OK};
          end else begin
            resp_d = {prdata_i, RSP_OK};
            left_d = 3'd5;
          end
        end else if (wait_q == TO_W'(TO_LAST)) begin
          resp_d     = {32'h0, RSP_TO};
          left_d     = 3'd1;
          tx_valid_d = 1'b1;
          timeout_d  = 1'b1;
          state_d    = RESP;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      RESP: begin
        if (tx_ready_i) begin
          if (left_q == 3'd1) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            resp_d = resp_q >> 8;
            left_d = left_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d == APB_SETUP) || (state_d == APB_ACCESS);
    penable_d = (state_d == APB_ACCESS);
    busy_d    = (state_d != IDLE);
  end

  // Dropped bytes are flagged in the cycle they arrive
  assign overrun_o = rx_valid_i &&
                     (state_q == APB_SETUP || state_q == APB_ACCESS || state_q == RESP);

  assign tx_data_o  = resp_q[7:0];
  assign tx_valid_o = tx_valid_q;
  assign psel_o     = psel_q;
  assign penable_o  = penable_q;
  assign pwrite_o   = pwrite_q;
  assign paddr_o    = paddr_q;
  assign pwdata_o   = pwdata_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// tb_uart_apb_master: directed and randomized command frames against a
// frame-level reference model of the expected response bytes.
module tb_uart_apb_master;

  localparam int unsigned TO  = 8;
  localparam int unsigned FTO = 20;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        busy, overrun, timeout;

  always #5 clk = ~clk;

  uart_apb_master #(.TIMEOUT_CYCLES(TO), .FRAME_TIMEOUT_CYCLES(FTO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr),
    .busy_o(busy), .overrun_o(overrun), .timeout_o(timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: response bytes as a function of the frame and the slave's answer
  task automatic model(input logic [7:0] op, input int lat, input bit err, input logic [31:0] rd);
    exp_q.delete();
    if (op != 8'h57 && op != 8'h52) exp_q.push_back(8'h3F);
    else if (lat < 0)               exp_q.push_back(8'h54);
    else if (err)                   exp_q.push_back(8'h45);
    else begin
      exp_q.push_back(8'h4B);
      if (op == 8'h52)
        for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
    end
  endtask

  // Drive one rx byte for one cycle; returns #1 after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] wd);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_byte(addr);
      if (op == 8'h57)
        for (int i = 0; i < 4; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          send_byte(wd[8*i +: 8]);
        end
    end
  endtask

  // lat < 0: slave never answers; otherwise pready on ACCESS cycle lat+1
  task automatic run_txn(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int lat, input bit err,
                         input bit stall, input bit poke);
    int  acc;
    bit  done;
    bit  prev_wait;
    int  stall_left;
    bit  rdy;
    logic [7:0] prev_data;
    model(op, lat, err, rd);
    got_q.delete();
    send_frame(op, addr, wd);
    if (op == 8'h57 || op == 8'h52) begin
      check("setup_psel",    40'({psel, penable}), 40'(2'b10));
      check("setup_paddr",   40'(paddr), 40'(addr));
      check("setup_pwrite",  40'(pwrite), 40'(op == 8'h57));
      if (op == 8'h57) check("setup_pwdata", 40'(pwdata), 40'(wd));
      acc  = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(posedge clk); #1;
        if (psel && penable) begin
          acc++;
          check("access_paddr", 40'(paddr), 40'(addr));
          pready  = (lat >= 0) && (acc == lat + 1);
          prdata  = pready ? rd : 32'hDEAD_BEEF;
          pslverr = pready ? err : 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      check("access_cycles", 40'(acc), (lat < 0) ? 40'(TO) : 40'(lat + 1));
      check("psel_drop",     40'({psel, penable}), 40'(0));
      check("timeout_pulse", 40'(timeout), 40'(lat < 0));
    end
    check("tx_valid_start", 40'(tx_valid), 40'(1));
    prev_wait  = 1'b0;
    prev_data  = '0;
    stall_left = 0;
    for (int c = 0; c < 300; c++) begin
      if (c == 1) check("timeout_low", 40'(timeout), 40'(0));
      if (prev_wait) begin
        check("tx_valid_hold", 40'(tx_valid), 40'(1));
        check("tx_data_hold",  40'(tx_data), 40'(prev_data));
      end
      if (!tx_valid) break;
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      tx_ready = rdy;
      if (poke && c == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'h52;
        #1;
        check("overrun", 40'(overrun), 40'(1));
      end
      if (rdy) begin
        got_q.push_back(tx_data);
        if (stall && got_q.size() == 1) stall_left = 10;
      end
      prev_wait = !rdy;
      prev_data = tx_data;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
    end
    check("resp_len", 40'(got_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("resp_byte", 40'(got_q[i]), 40'(exp_q[i]));
    check("busy_end", 40'(busy), 40'(0));
    repeat (2) @(posedge clk);
    #1;
    check("idle_after", 40'({busy, tx_valid, psel}), 40'(0));
  endtask

  initial begin
    logic [7:0]  op;
    int          lat;
    bit          saw;
    reset_i  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    prdata   = '0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 40'({psel, penable, pwrite, tx_valid, busy, overrun, timeout}), 40'(0));
    check("rst_data", 40'({tx_data, paddr, pwdata}), 40'(0));
    reset_i = 1'b0;

    // Directed cases
    run_txn(8'h57, 8'h14, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    run_txn(8'h52, 8'h00, 32'h0, 32'hA5C3_0011, 2, 1'b0, 1'b1, 1'b0);
    run_txn(8'h52, 8'h20, 32'h0, 32'h1111_2222, 1, 1'b1, 1'b0, 1'b0);
    run_txn(8'h57, 8'h04, 32'hCAFE_F00D, 32'h0, 0, 1'b1, 1'b0, 1'b0);
    run_txn(8'h52, 8'h30, 32'h0, 32'h0, -1, 1'b0, 1'b0, 1'b0);
    run_txn(8'h52, 8'h30, 32'h0, 32'h8765_4321, 0, 1'b0, 1'b0, 1'b0);
    run_txn(8'h41, 8'h00, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);

    // Incomplete frame is discarded after the inter-byte timeout
    send_byte(8'h57);
    send_byte(8'h10);
    saw = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (tx_valid || psel) saw = 1'b1;
      if (c == 10) check("frame_busy", 40'(busy), 40'(1));
      @(posedge clk); #1;
    end
    check("frame_drop_busy", 40'(busy), 40'(0));
    check("frame_drop_tx",   40'(saw), 40'(0));

    // Reset in the middle of an ACCESS phase
    send_byte(8'h52);
    send_byte(8'h0C);
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_access", 40'({psel, penable}), 40'(2'b11));
    reset_i = 1'b1;
    #1;
    check("async_rst", 40'({psel, penable, tx_valid, busy}), 40'(0));
    @(posedge clk); #1;
    reset_i = 1'b0;
    run_txn(8'h52, 8'h0C, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 1'b0);

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       begin
                   op = 8'($urandom_range(0, 255));
                   if (op == 8'h57 || op == 8'h52) op = 8'h00;
                 end
        1, 2, 3, 4: op = 8'h57;
        default: op = 8'h52;
      endcase
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_txn(op, 8'($urandom), 32'($urandom), 32'($urandom), lat,
              $urandom_range(0, 4) == 0, 1'b0, $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
